// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the RISC_TOY unified-memory arbiter.
package toy_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSP_I = 2'd1,
    RSP_D = 2'd2
  } rsp_state_e;

  localparam int DEF_AW = 30;
  localparam int DEF_DW = 32;

  localparam logic DRW_WRITE = 1'b1;
  localparam logic DRW_READ  = 1'b0;

endpackage

// File: rtl/toy_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module toy_sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/toy_mem_arbiter.sv
// Fetch/data arbiter for one single-port SRAM: data has priority, fetch wins after STARVE_MAX denials.
// Defining TOY_ARB_STATS_EN adds saturating conflict/override statistics outputs.
module toy_mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4,
  parameter int SCW        = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [DW-1:0] D_RDATA,
  output logic          M_REQ,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA
`ifdef TOY_ARB_STATS_EN
  ,
  output logic [15:0]   STAT_CONFLICT,
  output logic [15:0]   STAT_OVERRIDE
`endif
);

  rsp_state_e     state_q, state_d;
  logic [SCW-1:0] starve_cnt;
  logic           starve_hit;
  logic           i_gnt, d_gnt;

  assign starve_hit = (starve_cnt == SCW'(STARVE_MAX));

  // Grants are gated by RSTN so nothing reaches memory while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (RSTN) begin
      i_gnt = I_REQ && (!D_REQ || starve_hit);
      d_gnt = D_REQ && !i_gnt;
    end
  end

  always_comb begin
    M_REQ   = i_gnt | d_gnt;
    M_WE    = d_gnt && (D_RW == DRW_WRITE);
    M_ADDR  = '0;
    M_WDATA = '0;
    if (i_gnt) begin
      M_ADDR = I_ADDR;
    end else if (d_gnt) begin
      M_ADDR = D_ADDR;
    end
    if (M_REQ) begin
      M_WDATA = D_WDATA;
    end
  end

  toy_sat_counter #(
    .W   (SCW),
    .MAX (SCW'(STARVE_MAX))
  ) u_starve_cnt (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .clr_i  (i_gnt || !I_REQ),
    .inc_i  (I_REQ && !i_gnt),
    .cnt_o  (starve_cnt)
  );

  // The response slot is rewritten every cycle, so back-to-back reads pipeline.
  always_comb begin
    state_d = IDLE;
    if (i_gnt) begin
      state_d = RSP_I;
    end else if (d_gnt && (D_RW == DRW_READ)) begin
      state_d = RSP_D;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign I_GNT    = i_gnt;
  assign D_GNT    = d_gnt;
  assign I_RVALID = (state_q == RSP_I);
  assign D_RVALID = (state_q == RSP_D);
  assign I_RDATA  = RSTN ? M_RDATA : '0;
  assign D_RDATA  = RSTN ? M_RDATA : '0;

`ifdef TOY_ARB_STATS_EN
  toy_sat_counter #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_stat_conflict (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .clr_i  (1'b0),
    .inc_i  (I_REQ && D_REQ),
    .cnt_o  (STAT_CONFLICT)
  );

  toy_sat_counter #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_stat_override (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .clr_i  (1'b0),
    .inc_i  (i_gnt && D_REQ && starve_hit),
    .cnt_o  (STAT_OVERRIDE)
  );
`endif

endmodule

// File: doc/toy_mem_arbiter.md
Name: toy_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the RISC_TOY instruction-fetch port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Grants at most one memory access per cycle, with fixed priority to data and an anti-starvation override for fetch.
- Tracks the outstanding read so that data returning one cycle later goes to the correct requester.
- Sits between the core and the unified memory macro.

Parameters:
- AW, 30, word-address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets forced priority (1..15).
- SCW, 4, starvation counter width; must hold STARVE_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- I_REQ  in  1  fetch request.
- I_ADDR  in  AW  fetch word address.
- I_GNT  out  1  fetch accepted this cycle.
- I_RVALID  out  1  I_RDATA valid; asserted the cycle after I_GNT.
- I_RDATA  out  DW  fetch read data.
- D_REQ  in  1  data request.
- D_RW  in  1  1 = write, 0 = read.
- D_ADDR  in  AW  data word address.
- D_WDATA  in  DW  write data.
- D_GNT  out  1  data access accepted this cycle; a write completes on D_GNT.
- D_RVALID  out  1  D_RDATA valid; asserted the cycle after a read D_GNT.
- D_RDATA  out  DW  data read data.
- M_REQ  out  1  memory enable.
- M_WE  out  1  memory write enable.
- M_ADDR  out  AW  memory address.
- M_WDATA  out  DW  memory write data.
- M_RDATA  in  DW  memory read data, valid the cycle after M_REQ with M_WE=0.

Behaviour:
- Grant selection is combinational from the requests and the registered starvation count. There is zero-cycle acceptance, and a new grant can issue every cycle.
- Priority: if only one requester is active, it is granted.
  - If both are active: D wins, unless starve_cnt == STARVE_MAX, in which case I wins.
- Memory drive follows the winner:
  - M_REQ = I_GNT|D_GNT.
  - M_WE = D_GNT & D_RW.
  - M_ADDR = winner's address.
  - M_WDATA = D_WDATA.
  - When M_REQ=0, M_ADDR, M_WDATA and M_WE are 0.
- starve_cnt:
  - Clears when I_GNT or !I_REQ.
  - Otherwise increments each cycle I_REQ & !I_GNT, saturating at STARVE_MAX.
- Response FSM, registered, updated every cycle from the current grant:
  - IDLE: no read outstanding.
  - RSP_I: fetch read outstanding.
  - RSP_D: data read outstanding.
  - Next state: I_GNT → RSP_I; D_GNT & !D_RW → RSP_D; otherwise (write grant or no grant) → IDLE. This applies from any state, so back-to-back reads pipeline.
- Outputs by state:
  - I_RVALID = (state==RSP_I); D_RVALID = (state==RSP_D).
  - I_RDATA and D_RDATA are both wired to M_RDATA; RVALID qualifies them.
- Requesters hold REQ, address and data stable until GNT. The arbiter does not latch requests.
- A write followed by a read to the same address in the next cycle returns the new data; the memory provides this ordering.
- Reset (RSTN low, at any time including with a read outstanding):
  - State goes to IDLE and starve_cnt to 0.
  - All outputs are 0 and grants are gated off.
  - An in-flight response is dropped and no RVALID is issued after reset release.
  - First grant is possible in the first cycle with RSTN high.

Optional Feature:
- TOY_ARB_STATS_EN defined adds two outputs:
  - STAT_CONFLICT (16b): counts cycles with I_REQ & D_REQ.
  - STAT_OVERRIDE (16b): counts cycles in which I won because starve_cnt == STARVE_MAX.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: those ports and counters do not exist; arbitration behaviour is identical either way.

Decomposition:
- Package toy_mem_pkg:
  - Response-state enum (IDLE=2'd0, RSP_I=2'd1, RSP_D=2'd2).
  - Default AW/DW constants.
  - DRW encoding constants (DRW_WRITE=1, DRW_READ=0).
- One natural sub-module, toy_sat_counter (parameterised width/max, inc, clr), reused for starve_cnt and the stats counters.

Test Plan:
- Fetch only: I_REQ=1 for 3 cycles at I_ADDR 0,1,2 with memory[k]=32'hA000_000k.
  - Required: I_GNT each cycle; I_RVALID the following cycles with A0000000, A0000001, A0000002; D_RVALID stays 0.
- Conflict read: I_REQ and D_REQ (D_RW=0, D_ADDR=10) in the same cycle.
  - Required: D_GNT=1, I_GNT=0, M_ADDR=10; next cycle D_RVALID=1 with mem[10]; I is granted once D drops.
- Starvation with STARVE_MAX=4: D_REQ and I_REQ both held high.
  - Required: D granted 4 cycles, I granted on the 5th (STAT_OVERRIDE=1 if enabled), D granted on the 6th.
- Write then read: D write 32'hDEAD_BEEF to addr 5, then D read addr 5.
  - Required: M_WE=1 in cycle 1 with no RVALID in cycle 2; D_RVALID with DEADBEEF in cycle 3.
- Reset mid-read: grant an I read, then assert RSTN low before the response cycle.
  - Required: all outputs 0; no I_RVALID after release; first new I_REQ is granted immediately.
